// File: rtl/axi128_pkg.sv
// Shared widths, skid-buffer state and response codes for the 128-bit AXI
// register slice.
package axi128_pkg;

    localparam int AXI_DATA_W = 128;
    localparam int AXI_STRB_W = 16;
    localparam int AXI_ID_W   = 8;
    localparam int AXI_ADDR_W = 40;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    localparam logic [1:0] OKAY = 2'b00;

endpackage

// File: rtl/axi_skid_buf.sv
// Two-entry skid buffer: source ready and sink valid/payload come straight
// from flops, so neither side sees a combinational path through the slice.
module axi_skid_buf
    import axi128_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             pll_core_cpuclk,
    input  logic             pad_cpu_rst_b,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             src_ready,
    output logic             snk_valid,
    output logic [WIDTH-1:0] snk_data,
    input  logic             snk_ready
);

    skid_state_e      state;
    logic [WIDTH-1:0] skid_q;
    logic             push;
    logic             pop;

    assign push = src_valid & src_ready;
    assign pop  = snk_valid & snk_ready;

    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            state     <= SKID_EMPTY;
            src_ready <= 1'b1;
            snk_valid <= 1'b0;
            snk_data  <= '0;
            skid_q    <= '0;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (push) begin
                        snk_data  <= src_data;
                        snk_valid <= 1'b1;
                        state     <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (push && !pop) begin
                        skid_q    <= src_data;
                        src_ready <= 1'b0;
                        state     <= SKID_TWO;
                    end else if (push) begin
                        snk_data <= src_data;
                    end else if (pop) begin
                        snk_valid <= 1'b0;
                        state     <= SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    // ready is low here, so only a drain can happen
                    if (pop) begin
                        snk_data  <= skid_q;
                        src_ready <= 1'b1;
                        state     <= SKID_ONE;
                    end
                end
                default: begin
                    src_ready <= 1'b1;
                    snk_valid <= 1'b0;
                    state     <= SKID_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/axi_reg_slice128.sv
// 128-bit AXI register slice, one skid buffer per channel.
// Define AXI_SLICE_R_PIPE_EN to register the R channel; otherwise R passes through.
module axi_reg_slice128
    import axi128_pkg::*;
#(
    parameter int SV48_CONFIG = 0
) (
    input  logic                              pll_core_cpuclk,
    input  logic                              pad_cpu_rst_b,

    input  logic                              awvalid_m,
    input  logic [AXI_ADDR_W+SV48_CONFIG-1:0] awaddr_m,
    input  logic [AXI_ID_W-1:0]               awid_m,
    input  logic [7:0]                        awlen_m,
    input  logic [2:0]                        awsize_m,
    input  logic [1:0]                        awburst_m,
    input  logic [3:0]                        awcache_m,
    input  logic [2:0]                        awprot_m,
    output logic                              awready_m,

    input  logic                              wvalid_m,
    input  logic [AXI_DATA_W-1:0]             wdata_m,
    input  logic [AXI_STRB_W-1:0]             wstrb_m,
    input  logic [AXI_ID_W-1:0]               wid_m,
    input  logic                              wlast_m,
    output logic                              wready_m,

    input  logic                              arvalid_m,
    input  logic [AXI_ADDR_W-1:0]             araddr_m,
    input  logic [AXI_ID_W-1:0]               arid_m,
    input  logic [7:0]                        arlen_m,
    input  logic [2:0]                        arsize_m,
    input  logic [1:0]                        arburst_m,
    input  logic [3:0]                        arcache_m,
    input  logic [2:0]                        arprot_m,
    output logic                              arready_m,

    output logic                              bvalid_m,
    output logic [AXI_ID_W-1:0]               bid_m,
    output logic [1:0]                        bresp_m,
    input  logic                              bready_m,

    output logic                              rvalid_m,
    output logic [AXI_DATA_W-1:0]             rdata_m,
    output logic [AXI_ID_W-1:0]               rid_m,
    output logic [1:0]                        rresp_m,
    output logic                              rlast_m,
    input  logic                              rready_m,

    output logic                              awvalid_s0,
    output logic [AXI_ADDR_W+SV48_CONFIG-1:0] awaddr_s0,
    output logic [AXI_ID_W-1:0]               awid_s0,
    output logic [7:0]                        awlen_s0,
    output logic [2:0]                        awsize_s0,
    output logic [1:0]                        awburst_s0,
    output logic [3:0]                        awcache_s0,
    output logic [2:0]                        awprot_s0,
    input  logic                              awready_s0,

    output logic                              wvalid_s0,
    output logic [AXI_DATA_W-1:0]             wdata_s0,
    output logic [AXI_STRB_W-1:0]             wstrb_s0,
    output logic [AXI_ID_W-1:0]               wid_s0,
    output logic                              wlast_s0,
    input  logic                              wready_s0,

    output logic                              arvalid_s0,
    output logic [AXI_ADDR_W-1:0]             araddr_s0,
    output logic [AXI_ID_W-1:0]               arid_s0,
    output logic [7:0]                        arlen_s0,
    output logic [2:0]                        arsize_s0,
    output logic [1:0]                        arburst_s0,
    output logic [3:0]                        arcache_s0,
    output logic [2:0]                        arprot_s0,
    input  logic                              arready_s0,

    input  logic                              bvalid_s0,
    input  logic [AXI_ID_W-1:0]               bid_s0,
    input  logic [1:0]                        bresp_s0,
    output logic                              bready_s0,

    input  logic                              rvalid_s0,
    input  logic [AXI_DATA_W-1:0]             rdata_s0,
    input  logic [AXI_ID_W-1:0]               rid_s0,
    input  logic [1:0]                        rresp_s0,
    input  logic                              rlast_s0,
    output logic                              rready_s0
);

    localparam int AW_W = AXI_ADDR_W + SV48_CONFIG + AXI_ID_W + 20;
    localparam int W_W  = AXI_DATA_W + AXI_STRB_W + AXI_ID_W + 1;
    localparam int AR_W = AXI_ADDR_W + AXI_ID_W + 20;
    localparam int B_W  = AXI_ID_W + 2;

    logic [AW_W-1:0] aw_q;
    logic [W_W-1:0]  w_q;
    logic [AR_W-1:0] ar_q;
    logic [B_W-1:0]  b_q;

    axi_skid_buf #(.WIDTH(AW_W)) u_aw (
        .pll_core_cpuclk (pll_core_cpuclk),
        .pad_cpu_rst_b   (pad_cpu_rst_b),
        .src_valid       (awvalid_m),
        .src_data        ({awaddr_m, awid_m, awlen_m, awsize_m,
                           awburst_m, awcache_m, awprot_m}),
        .src_ready       (awready_m),
        .snk_valid       (awvalid_s0),
        .snk_data        (aw_q),
        .snk_ready       (awready_s0)
    );

    assign {awaddr_s0, awid_s0, awlen_s0, awsize_s0,
            awburst_s0, awcache_s0, awprot_s0} = aw_q;

    axi_skid_buf #(.WIDTH(W_W)) u_w (
        .pll_core_cpuclk (pll_core_cpuclk),
        .pad_cpu_rst_b   (pad_cpu_rst_b),
        .src_valid       (wvalid_m),
        .src_data        ({wdata_m, wstrb_m, wid_m, wlast_m}),
        .src_ready       (wready_m),
        .snk_valid       (wvalid_s0),
        .snk_data        (w_q),
        .snk_ready       (wready_s0)
    );

    assign {wdata_s0, wstrb_s0, wid_s0, wlast_s0} = w_q;

    axi_skid_buf #(.WIDTH(AR_W)) u_ar (
        .pll_core_cpuclk (pll_core_cpuclk),
        .pad_cpu_rst_b   (pad_cpu_rst_b),
        .src_valid       (arvalid_m),
        .src_data        ({araddr_m, arid_m, arlen_m, arsize_m,
                           arburst_m, arcache_m, arprot_m}),
        .src_ready       (arready_m),
        .snk_valid       (arvalid_s0),
        .snk_data        (ar_q),
        .snk_ready       (arready_s0)
    );

    assign {araddr_s0, arid_s0, arlen_s0, arsize_s0,
            arburst_s0, arcache_s0, arprot_s0} = ar_q;

    axi_skid_buf #(.WIDTH(B_W)) u_b (
        .pll_core_cpuclk (pll_core_cpuclk),
        .pad_cpu_rst_b   (pad_cpu_rst_b),
        .src_valid       (bvalid_s0),
        .src_data        ({bid_s0, bresp_s0}),
        .src_ready       (bready_s0),
        .snk_valid       (bvalid_m),
        .snk_data        (b_q),
        .snk_ready       (bready_m)
    );

    assign {bid_m, bresp_m} = b_q;

`ifdef AXI_SLICE_R_PIPE_EN
    localparam int R_W = AXI_DATA_W + AXI_ID_W + 3;

    logic [R_W-1:0] r_q;

    axi_skid_buf #(.WIDTH(R_W)) u_r (
        .pll_core_cpuclk (pll_core_cpuclk),
        .pad_cpu_rst_b   (pad_cpu_rst_b),
        .src_valid       (rvalid_s0),
        .src_data        ({rdata_s0, rid_s0, rresp_s0, rlast_s0}),
        .src_ready       (rready_s0),
        .snk_valid       (rvalid_m),
        .snk_data        (r_q),
        .snk_ready       (rready_m)
    );

    assign {rdata_m, rid_m, rresp_m, rlast_m} = r_q;
`else
    // Read data returns with zero added latency in this build
    assign rvalid_m  = rvalid_s0;
    assign rdata_m   = rdata_s0;
    assign rid_m     = rid_s0;
    assign rresp_m   = rresp_s0;
    assign rlast_m   = rlast_s0;
    assign rready_s0 = rready_m;
`endif

endmodule
